// File: rtl/fifo_pack_8to32.sv
// fifo_pack_8to32: drains a byte FIFO and packs ratio lanes per word.
// Partial words are emitted on flush with a lane-keep mask.
module fifo_pack_8to32 #(
  parameter int data_width = 8,
  parameter int ratio      = 4
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          empty,
  input  logic [data_width-1:0]         data_out,
  output logic                          r_en,
  input  logic                          flush,
  output logic [data_width*ratio-1:0]   out_data,
  output logic [ratio-1:0]              out_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          flush_busy
);

  localparam int IW = $clog2(ratio);
  localparam int NW = IW + 1;
  localparam logic [NW-1:0] LAST_N = NW'(ratio - 1);
  localparam logic [IW-1:0] LAST_I = IW'(ratio - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                              state_q, state_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic                                rd_pend_q, rd_pend_d;
  logic [ratio-1:0][data_width-1:0]    asm_q, asm_d;
  logic [data_width*ratio-1:0]         out_data_q, out_data_d;
  logic [ratio-1:0]                    out_keep_q, out_keep_d;
  logic                                out_valid_q, out_valid_d;

  logic [NW-1:0]                       nlane;
  logic                                out_free;
  logic [data_width*ratio-1:0]         part_data;
  logic [ratio-1:0]                    part_keep;

  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_valid  = out_valid_q;
  assign flush_busy = (state_q == FLUSH);

  // Pop gating: hold off a pop whose byte would complete a blocked word.
  always_comb begin
    nlane    = {1'b0, idx_q} + {{IW{1'b0}}, rd_pend_q};
    out_free = !out_valid_q || out_ready;
    r_en     = clr_n && !empty && (state_q == RUN)
               && !((nlane == LAST_N) && out_valid_q && !out_ready);
  end

  // Partial word view: lanes below idx, upper lanes zeroed.
  always_comb begin
    part_data = '0;
    part_keep = '0;
    for (int i = 0; i < ratio; i++) begin
      if (IW'(i) < idx_q) begin
        part_data[i*data_width +: data_width] = asm_q[i];
        part_keep[i] = 1'b1;
      end
    end
  end

  // Next state: byte capture, output handshake and flush sequencing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_pend_d   = r_en;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q && !out_ready;

    if (rd_pend_q) begin
      asm_d[idx_q] = data_out;
      if (idx_q == LAST_I) begin
        out_data_d  = asm_d;
        out_keep_d  = '1;
        out_valid_d = 1'b1;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    unique case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (!rd_pend_q && out_free) begin
          if (idx_q != '0) begin
            out_data_d  = part_data;
            out_keep_d  = part_keep;
            out_valid_d = 1'b1;
            idx_d       = '0;
          end
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= RUN;
      idx_q       <= '0;
      rd_pend_q   <= 1'b0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_pend_q   <= rd_pend_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_pack_8to32.sv
// tb_fifo_pack_8to32: byte FIFO model feeding the packer,
// checked cycle by cycle against a queue-based reference.
module tb_fifo_pack_8to32;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        empty;
  logic [7:0]  data_out;
  logic        r_en;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        flush_busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  fq[$];
  logic [35:0] acc_q[$];

  logic [7:0]  m_asm[$];
  bit          m_pend;
  bit          m_flush;
  bit          m_ov;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [7:0]  m_byte;

  fifo_pack_8to32 #(.data_width(8), .ratio(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .empty      (empty),
    .data_out   (data_out),
    .r_en       (r_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_busy (flush_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_asm.delete();
    m_pend  = 0;
    m_flush = 0;
    m_ov    = 0;
    m_data  = '0;
    m_keep  = '0;
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cyc();
    bit          exp_ren;
    bit          ren;
    bit          acc;
    bit          load;
    bit          fl_old;
    int          held;
    logic [31:0] w;
    logic [3:0]  k;
    empty = (fq.size() == 0);
    #1;
    held = m_asm.size() + int'(m_pend);
    exp_ren = clr_n && (fq.size() > 0) && !m_flush
              && !(held == 3 && m_ov && !out_ready);
    chk("r_en", r_en, exp_ren);
    ren = r_en && (fq.size() > 0);
    if (out_valid && out_ready) acc_q.push_back({out_keep, out_data});
    acc = m_ov && out_ready;
    @(posedge clk);
    #1;
    load   = 0;
    fl_old = m_flush;
    w      = '0;
    k      = '0;
    if (m_pend) begin
      m_asm.push_back(m_byte);
      if (m_asm.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          w[8*i +: 8] = m_asm[i];
          k[i] = 1'b1;
        end
        load = 1;
        m_asm.delete();
      end
    end else if (fl_old && (!m_ov || out_ready)) begin
      if (m_asm.size() > 0) begin
        for (int i = 0; i < m_asm.size(); i++) begin
          w[8*i +: 8] = m_asm[i];
          k[i] = 1'b1;
        end
        load = 1;
      end
      m_asm.delete();
      m_flush = 0;
    end
    if (!fl_old && flush) m_flush = 1;
    if (load) begin
      m_ov   = 1;
      m_data = w;
      m_keep = k;
    end else if (acc) begin
      m_ov = 0;
    end
    m_pend = ren;
    if (ren) begin
      data_out = fq.pop_front();
      m_byte   = data_out;
    end else begin
      data_out = 8'($urandom);
    end
    chk("out_valid", out_valid, m_ov);
    chk("flush_busy", flush_busy, m_flush);
    if (m_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_keep", out_keep, m_keep);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d,
                             input logic [3:0] k);
    logic [35:0] e;
    chk({tag, "_cnt"}, acc_q.size() > 0, 1);
    if (acc_q.size() > 0) begin
      e = acc_q.pop_front();
      chk({tag, "_data"}, e[31:0], d);
      chk({tag, "_keep"}, e[35:32], k);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    clr_n     = 1'b1;
    empty     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    data_out  = '0;
    model_reset();
    #2 clr_n = 1'b0;
    #1;
    chk("rst_r_en", r_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", flush_busy, 0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;

    push_seq(8'h01, 4);
    run(8);
    expect_word("basic", 32'h04030201, 4'hF);

    out_ready = 1'b0;
    push_seq(8'h11, 8);
    run(12);
    chk("bp_held", out_data, 32'h14131211);
    chk("bp_left", fq.size(), 1);
    out_ready = 1'b1;
    run(10);
    expect_word("bp_w1", 32'h14131211, 4'hF);
    expect_word("bp_w2", 32'h18171615, 4'hF);

    push_seq(8'h05, 3);
    run(4);
    pulse_flush();
    run(4);
    expect_word("part", 32'h00070605, 4'h7);

    push_seq(8'h0A, 2);
    cyc();
    pulse_flush();
    run(5);
    expect_word("inflt", 32'h00000B0A, 4'h3);

    pulse_flush();
    run(3);
    chk("fl_empty_none", acc_q.size(), 0);

    push_seq(8'h41, 4);
    run(4);
    pulse_flush();
    run(4);
    expect_word("fl_cmpl", 32'h44434241, 4'hF);
    chk("fl_cmpl_none", acc_q.size(), 0);

    out_data_prev_nonzero_check();

    push_seq(8'h21, 2);
    run(3);
    #2;
    fq.push_back(8'h99);
    empty = 1'b0;
    #1;
    chk("pre_rst_ren", r_en, 1);
    clr_n = 1'b0;
    #1;
    chk("mid_rst_r_en", r_en, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_keep", out_keep, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", flush_busy, 0);
    fq.delete();
    empty = 1'b1;
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    push_seq(8'h31, 4);
    run(8);
    expect_word("post_rst", 32'h34333231, 4'hF);
    chk("post_rst_none", acc_q.size(), 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0 && fq.size() < 16)
        fq.push_back(8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cyc();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    run(24);
    pulse_flush();
    run(6);
    chk("rand_drained", fq.size(), 0);
    acc_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  task automatic out_data_prev_nonzero_check();
    chk("hold_data", out_data, 32'h44434241);
  endtask

endmodule
